// File: rtl/chroma_upsample_ctrl.sv
// Collects one 4:2:0 MCU (Y0..Y3, Cb, Cr) and replays it as four luma/chroma quadrant sets.
// Latency: first quadrant is presented 1 cycle after the 6th accepted block; 4 emit cycles minimum.
// Backpressure: in_ready is low for the whole emit phase; outputs hold while out_valid && !out_ready.
module chroma_upsample_ctrl #(
    parameter  int CH = 3,
    localparam int CW = $clog2(CH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         in_ch,
    input  logic [7:0][7:0][8:0]  in_block,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0][7:0][8:0]  out_y,
    output logic [3:0][3:0][8:0]  out_cb,
    output logic [3:0][3:0][8:0]  out_cr,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  seq_err
);

    typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [CW-1:0] TAG_Y  = CW'(0);
    localparam logic [CW-1:0] TAG_CB = CW'(1);
    localparam logic [CW-1:0] TAG_CR = CW'(2);

    state_t            state_q, state_d;
    logic [2:0]        seq_q, seq_d;
    logic [1:0]        idx_q, idx_d;
    logic              err_q, err_d;
    logic [CW-1:0]     exp_ch;
    logic              accept;
    logic              store;

    // Block buffers; contents are only meaningful once a full MCU has been collected.
    logic [7:0][7:0][8:0] y_q [4];
    logic [7:0][7:0][8:0] cb_q;
    logic [7:0][7:0][8:0] cr_q;

    // Handshakes are forced low while reset is held so nothing is accepted or presented.
    assign in_ready  = (state_q == COLLECT) && !reset;
    assign out_valid = (state_q == EMIT) && !reset;
    assign accept    = in_valid && in_ready;
    assign store     = accept && (in_ch == exp_ch);
    assign seq_err   = err_q;

    // Expected channel tag for the current sequence position: Y,Y,Y,Y,Cb,Cr.
    always_comb begin
        exp_ch = TAG_Y;
        if (seq_q == 3'd4) begin
            exp_ch = TAG_CB;
        end else if (seq_q >= 3'd5) begin
            exp_ch = TAG_CR;
        end
    end

    // State, sequence counter, quadrant index and sticky error register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
            seq_q   <= 3'd0;
            idx_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: collect six in-order blocks, then step through four quadrants.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (store) begin
                        if (seq_q == 3'd5) begin
                            state_d = EMIT;
                            seq_d   = 3'd0;
                            idx_d   = 2'd0;
                        end else begin
                            seq_d = seq_q + 3'd1;
                        end
                    end else begin
                        // Out-of-order tag: block is dropped and the sequence position kept.
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == 2'd3) begin
                        state_d = COLLECT;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Buffer writes for in-order blocks; no reset needed since every MCU overwrites all six.
    always_ff @(posedge clock) begin
        if (store) begin
            case (seq_q)
                3'd0, 3'd1, 3'd2, 3'd3: y_q[seq_q[1:0]] <= in_block;
                3'd4:                   cb_q            <= in_block;
                default:                cr_q            <= in_block;
            endcase
        end
    end

    assign out_y    = out_valid ? y_q[idx_q] : '0;
    assign out_idx  = out_valid ? idx_q : 2'd0;
    assign out_last = out_valid && (idx_q == 2'd3);

    // Quadrant k selects chroma rows 4*(k>>1).. and columns 4*(k&1)..
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign out_cb[r][c] = out_valid ? cb_q[{idx_q[1], 2'(r)}][{idx_q[0], 2'(c)}] : 9'd0;
            assign out_cr[r][c] = out_valid ? cr_q[{idx_q[1], 2'(r)}][{idx_q[0], 2'(c)}] : 9'd0;
        end
    end

endmodule

// File: tb/tb_chroma_upsample_ctrl.sv
// Directed bench for chroma_upsample_ctrl: per-cycle vector table plus hand-written sequences.
// Inputs change on the falling edge; outputs are compared 1 time unit later, before the rising edge.
// Expected values come from hand-computed constants and a small quadrant formula.
module tb_chroma_upsample_ctrl;

    typedef logic [7:0][7:0][8:0] blk_t;

    typedef struct {
        bit         rst;
        bit         vld;
        logic [1:0] ch;
        bit         kind;   // 0: constant fill with base, 1: base + 8*r + c
        int         base;
        bit         ordy;
        int         e_ir;
        int         e_ov;
        int         e_idx;
        int         e_last;
        int         e_err;
        int         e_y00;
        int         e_cb00;
        int         e_cr33;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        bit         kind;
        int         base;
    } src_t;

    logic                 clock;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_ch;
    blk_t                 in_block;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0][7:0][8:0] out_y;
    logic [3:0][3:0][8:0] out_cb;
    logic [3:0][3:0][8:0] out_cr;
    logic [1:0]           out_idx;
    logic                 out_last;
    logic                 seq_err;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t vq[$];

    chroma_upsample_ctrl #(.CH(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_block (in_block),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_cb   (out_cb),
        .out_cr   (out_cr),
        .out_idx  (out_idx),
        .out_last (out_last),
        .seq_err  (seq_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic blk_t make_block(bit kind, int base);
        blk_t b;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b[r][c] = kind ? 9'(base + 8 * r + c) : 9'(base);
            end
        end
        return b;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // One full-quadrant comparison: Y block is constant ybase+k, chroma are ramps.
    task automatic chk_quad(string nm, int ybase, int cbb, int crb, int k);
        bit ok;
        int ecb;
        int ecr;
        ok = out_valid && (int'(out_idx) == k) && (out_last == (k == 3));
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (int'(out_y[r][c]) != ybase + k) ok = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ecb = cbb + 8 * (4 * (k / 2) + r) + 4 * (k % 2) + c;
                ecr = crb + 8 * (4 * (k / 2) + r) + 4 * (k % 2) + c;
                if (int'(out_cb[r][c]) != ecb || int'(out_cr[r][c]) != ecr) ok = 1'b0;
            end
        end
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s k=%0d: got vld=%0d idx=%0d last=%0d y00=%0d cb00=%0d cr00=%0d, expected vld=1 idx=%0d last=%0d y=%0d cb00=%0d cr00=%0d",
                      nm, k, out_valid, out_idx, out_last, out_y[0][0], out_cb[0][0], out_cr[0][0],
                      k, (k == 3), ybase + k, cbb + 32 * (k / 2) + 4 * (k % 2), crb + 32 * (k / 2) + 4 * (k % 2));
    endtask

    task automatic cyc(bit rst, bit vld, logic [1:0] ch, bit kind, int base, bit ordy);
        @(negedge clock);
        reset     = rst;
        in_valid  = vld;
        in_ch     = ch;
        in_block  = make_block(kind, base);
        out_ready = ordy;
        #1;
    endtask

    task automatic send_mcu(int ybase, int cbb, int crb);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd0, 1'b0, ybase + i, 1'b1);
        cyc(1'b0, 1'b1, 2'd1, 1'b1, cbb, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 1'b1, crb, 1'b1);
    endtask

    task automatic emit_all(string nm, int ybase, int cbb, int crb);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1);
            chk_quad(nm, ybase, cbb, crb, k);
        end
    endtask

    function automatic void add(bit rst, bit vld, logic [1:0] ch, bit kind, int base, bit ordy,
                                int ir, int ov, int idx, int last, int err, int y, int cb, int cr);
        vq.push_back('{rst, vld, ch, kind, base, ordy, ir, ov, idx, last, err, y, cb, cr});
    endfunction

    function automatic void add_rst(int err);
        add(1, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, err, 0, 0, 0);
    endfunction

    function automatic void add_in(logic [1:0] ch, bit kind, int base, int err);
        add(0, 1, ch, kind, base, 1, 1, 0, 0, 0, err, 0, 0, 0);
    endfunction

    function automatic void add_gap(int err);
        add(0, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, err, 0, 0, 0);
    endfunction

    function automatic void add_emit(int idx, int last, int y, int cb, int cr, int err);
        add(0, 0, 2'd0, 0, 0, 1, 0, 1, idx, last, err, y, cb, cr);
    endfunction

    // Quadrant outputs for Y=10/20/30/40, Cb=8r+c, Cr=100+8r+c.
    function automatic void add_basic_emits(int err);
        add_emit(0, 0, 10, 0, 127, err);
        add_emit(1, 0, 20, 4, 131, err);
        add_emit(2, 0, 30, 32, 159, err);
        add_emit(3, 1, 40, 36, 163, err);
    endfunction

    initial begin
        src_t bq[$];
        int   acc;
        int   e;
        int   gap;

        reset = 1'b1; in_valid = 1'b0; in_ch = 2'd0; in_block = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);

        // Basic MCU.
        add_rst(0);
        add_in(2'd0, 0, 10, 0); add_in(2'd0, 0, 20, 0); add_in(2'd0, 0, 30, 0); add_in(2'd0, 0, 40, 0);
        add_in(2'd1, 1, 0, 0);  add_in(2'd2, 1, 100, 0);
        add_basic_emits(0);
        add_gap(0);
        // Same MCU with idle cycles between blocks.
        add_in(2'd0, 0, 10, 0); add_gap(0); add_in(2'd0, 0, 20, 0); add_gap(0); add_gap(0);
        add_in(2'd0, 0, 30, 0); add_in(2'd0, 0, 40, 0); add_gap(0);
        add_in(2'd1, 1, 0, 0);  add_gap(0); add_in(2'd2, 1, 100, 0);
        add_basic_emits(0);
        add_gap(0);
        // Cb and reserved tag at seq 2 are dropped; the MCU still completes.
        add_in(2'd0, 0, 10, 0); add_in(2'd0, 0, 20, 0);
        add_in(2'd1, 1, 50, 0); add_in(2'd3, 0, 77, 1);
        add_in(2'd0, 0, 30, 1); add_in(2'd0, 0, 40, 1);
        add_in(2'd1, 1, 0, 1);  add_in(2'd2, 1, 100, 1);
        add_basic_emits(1);
        add_gap(1);
        add_rst(1);
        add_gap(0);

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].vld, vq[i].ch, vq[i].kind, vq[i].base, vq[i].ordy);
            chk($sformatf("v%0d.in_ready", i),  int'(in_ready),     vq[i].e_ir);
            chk($sformatf("v%0d.out_valid", i), int'(out_valid),    vq[i].e_ov);
            chk($sformatf("v%0d.out_idx", i),   int'(out_idx),      vq[i].e_idx);
            chk($sformatf("v%0d.out_last", i),  int'(out_last),     vq[i].e_last);
            chk($sformatf("v%0d.seq_err", i),   int'(seq_err),      vq[i].e_err);
            chk($sformatf("v%0d.y00", i),       int'(out_y[0][0]),  vq[i].e_y00);
            chk($sformatf("v%0d.cb00", i),      int'(out_cb[0][0]), vq[i].e_cb00);
            chk($sformatf("v%0d.cr33", i),      int'(out_cr[3][3]), vq[i].e_cr33);
        end

        // Backpressure at k=2 with in_valid held high.
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 0, 1'b1);
        send_mcu(1, 200, 300);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1); chk_quad("bp", 1, 200, 300, 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1); chk_quad("bp", 1, 200, 300, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 2'd0, 1'b0, 9, 1'b0);
            chk_quad($sformatf("bp_stall%0d", i), 1, 200, 300, 2);
            chk($sformatf("bp_stall%0d.in_ready", i), int'(in_ready), 0);
        end
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 9, 1'b1); chk_quad("bp_release", 1, 200, 300, 2);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1); chk_quad("bp_after", 1, 200, 300, 3);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1);
        chk("bp_done.out_valid", int'(out_valid), 0);
        chk("bp_done.in_ready", int'(in_ready), 1);

        // Reset mid-EMIT with seq_err set, then a fresh MCU.
        cyc(1'b0, 1'b1, 2'd3, 1'b0, 5, 1'b1);
        send_mcu(11, 20, 40);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1); chk_quad("rst_emit", 11, 20, 40, 0);
        chk("rst_emit.seq_err_set", int'(seq_err), 1);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0); chk_quad("rst_emit", 11, 20, 40, 1);
        cyc(1'b1, 1'b1, 2'd0, 1'b0, 0, 1'b1);
        chk("rst_held.out_valid", int'(out_valid), 0);
        chk("rst_held.in_ready", int'(in_ready), 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1);
        chk("rst_after.out_valid", int'(out_valid), 0);
        chk("rst_after.in_ready", int'(in_ready), 1);
        chk("rst_after.seq_err", int'(seq_err), 0);
        send_mcu(21, 60, 80);
        emit_all("fresh", 21, 60, 80);
        // Reset mid-COLLECT discards partial Y blocks.
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 99, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 98, 1'b1);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 0, 1'b1);
        send_mcu(51, 130, 170);
        emit_all("rst_collect", 51, 130, 170);
        chk("rst_collect.seq_err", int'(seq_err), 0);

        // Back-to-back MCUs with in_valid held high throughout.
        for (int i = 0; i < 4; i++) bq.push_back('{2'd0, 1'b0, 31 + i});
        bq.push_back('{2'd1, 1'b1, 70});
        bq.push_back('{2'd2, 1'b1, 90});
        for (int i = 0; i < 4; i++) bq.push_back('{2'd0, 1'b0, 41 + i});
        bq.push_back('{2'd1, 1'b1, 110});
        bq.push_back('{2'd2, 1'b1, 150});
        acc = 0; e = 0; gap = 0;
        for (int n = 0; n < 80 && e < 8; n++) begin
            if (bq.size() > 0) cyc(1'b0, 1'b1, bq[0].ch, bq[0].kind, bq[0].base, 1'b1);
            else               cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1);
            if (out_valid) begin
                if (e < 4) chk_quad("b2b_mcu1", 31, 70, 90, e % 4);
                else       chk_quad("b2b_mcu2", 41, 110, 150, e % 4);
                e++;
            end
            if (acc == 6 && !in_ready) gap++;
            if (in_valid && in_ready) begin
                void'(bq.pop_front());
                acc++;
            end
        end
        chk("b2b.quadrants_seen", e, 8);
        chk("b2b.blocks_accepted", acc, 12);
        chk("b2b.in_ready_low_cycles", gap, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
